mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multi-cycle MIPS control FSM.
- Sits directly upstream of the 32-bit 3-input datapath muxes.
- Drives pc_src (next-PC mux select), alu_src_b and all datapath enables, one instruction phase per state.
- Consumes opcode from the instruction register and a memory ready handshake.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- opcode  input  6  IR[31:26], stable from DECODE onward
- mem_ready  input  1  memory completed the current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero (branch)
- i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- reg_dst  output  1  write register: 0 = rt, 1 = rd
- mem_to_reg  output  1  write data: 0 = ALUOut, 1 = MDR
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A: 0 = PC, 1 = rs
- alu_src_b  output  2  ALU B: 00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  output  2  00 add, 01 sub, 10 use funct
- pc_src  output  2  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target; 11 never driven
- illegal_op  output  1  one-cycle pulse on an undefined opcode
- state  output  4  current state encoding, for debug

Behaviour:
- State register updates on the rising clk edge only.
- reset=1 at an edge: state <= FETCH, regardless of current state (including mid-memory-wait).
- While reset is high, every output is forced to 0, except state, which reads FETCH after the first reset edge.
- Outputs are Moore, decoded from state only; no input-to-output combinational path except the wait-state gating below.
- States and transitions:
  - FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. When mem_ready=1, ir_write=1 and pc_write=1 in that cycle, then go to DECODE. Otherwise hold FETCH with ir_write=pc_write=0.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
    - LW/SW -> MEM_ADDR
    - RTYPE -> EXECUTE
    - BEQ -> BRANCH
    - J -> JUMP
    - ADDI -> ADDI_EX
    - any other opcode -> FETCH, with illegal_op=1 in the DECODE cycle
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. LW -> MEM_READ; SW -> MEM_WRITE.
  - MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready=1, then go to MEM_WB.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
  - MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready=1, then FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Then R_WB.
  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01. Then FETCH.
  - JUMP: pc_write=1, pc_src=10. Then FETCH.
  - ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Then ADDI_WB.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- Unlisted outputs in any state are 0.
- pc_src=11 is never produced; an unreachable state encoding recovers to FETCH on the next edge with all outputs 0.
- mem_read and mem_write are never asserted together.
- Cycle counts with mem_ready tied high:
  - LW 5 cycles
  - SW, R-type and ADDI 4 cycles
  - BEQ and J 3 cycles
  - each mem_ready=0 cycle in a wait state adds one cycle

Decomposition:
- Shared package: state encodings (4-bit), opcode constants, alu_src_b/alu_op/pc_src select encodings.
- The package is also used by the datapath mux instantiations.
- One sub-module is natural: mc_control_decode, a purely combinational state-to-outputs decoder.
- The state register and next-state logic stay in mc_control.

Test Plan:
- Reset held 2 cycles mid-MEM_READ, then released -> all outputs 0 during reset; state=FETCH and mem_read=1 on the first cycle after release.
- LW (100011), mem_ready=1 -> states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, FETCH; reg_write=1 with mem_to_reg=1 only in cycle 5.
- BEQ (000100) -> pc_src=01 and pc_write_cond=1 exactly in cycle 3; pc_write=0 there.
- J (000010) -> pc_src=10 and pc_write=1 in cycle 3; pc_src never 11 across the whole run.
- SW (101011) with mem_ready low for 3 cycles in MEM_WRITE -> mem_write held 4 cycles, then FETCH; no reg_write.
- Opcode 6'b111111 -> illegal_op=1 for exactly the DECODE cycle, then FETCH; no writes asserted.

Source files
------------

// File: rtl/mc_control_pkg.sv
// rtl/mc_control_pkg.sv - shared encodings for the multi-cycle MIPS control FSM and datapath muxes
package mc_control_pkg;

    // FSM state encodings (4-bit, 12 used, 12..15 unreachable)
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ADDI_EX   = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;

    // Opcodes taken from IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU B operand select
    localparam logic [1:0] ALUB_RT      = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Next-PC select; 2'b11 is never produced by the controller
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for every opcode the FSM knows how to sequence
    function automatic logic is_known_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: is_known_op = 1'b1;
            default:                                       is_known_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_decode.sv
// rtl/mc_control_decode.sv - combinational state-to-control-signal decoder
module mc_control_decode
    import mc_control_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       blank,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op
);

    // Moore decode per state; only FETCH looks at mem_ready and only DECODE at opcode
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_RT;
        alu_op        = ALUOP_ADD;
        pc_src        = PCSRC_ALU;
        illegal_op    = 1'b0;
        if (!blank) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = ALUB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = ALUB_IMM_SH2;
                    illegal_op = !is_known_op(opcode);
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_src        = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = PCSRC_JUMP;
                end
                S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                end
                default: begin
                    // unreachable encodings leave every output at 0
                end
            endcase
        end
    end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS control FSM: state register, next-state logic, output decode
module mc_control
    import mc_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic [3:0] state
);

    logic [3:0] state_next;

    // State register; reset wins over any wait state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; wait states hold until mem_ready, unknown encodings fall back to FETCH
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:     state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDI_EX;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_next = S_FETCH;
            S_MEM_WRITE: state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_next = S_R_WB;
            S_R_WB:      state_next = S_FETCH;
            S_BRANCH:    state_next = S_FETCH;
            S_JUMP:      state_next = S_FETCH;
            S_ADDI_EX:   state_next = S_ADDI_WB;
            S_ADDI_WB:   state_next = S_FETCH;
            default:     state_next = S_FETCH;
        endcase
    end

    mc_control_decode u_decode (
        .state         (state),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .blank         (reset),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
        .illegal_op    (illegal_op)
    );

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - directed self-checking bench for mc_control
module tb_mc_control;

    // State encodings as documented for the debug port
    localparam logic [3:0] T_FETCH     = 4'd0;
    localparam logic [3:0] T_DECODE    = 4'd1;
    localparam logic [3:0] T_MEM_ADDR  = 4'd2;
    localparam logic [3:0] T_MEM_READ  = 4'd3;
    localparam logic [3:0] T_MEM_WB    = 4'd4;
    localparam logic [3:0] T_MEM_WRITE = 4'd5;
    localparam logic [3:0] T_EXECUTE   = 4'd6;
    localparam logic [3:0] T_R_WB      = 4'd7;
    localparam logic [3:0] T_BRANCH    = 4'd8;
    localparam logic [3:0] T_JUMP      = 4'd9;
    localparam logic [3:0] T_ADDI_EX   = 4'd10;
    localparam logic [3:0] T_ADDI_WB   = 4'd11;

    // Control word: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op}
    localparam logic [16:0] W_ZERO    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] W_F_RDY   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] W_F_WAIT  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] W_DEC     = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] W_DEC_ILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] W_ADDR    = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] W_MRD     = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] W_MWB     = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] W_MWR     = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] W_EXE     = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] W_RWB     = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] W_BR      = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] W_JMP     = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] W_AWB     = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;
    logic [16:0] ctl;

    int total = 0;
    int bad   = 0;

    mc_control dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: drive mem_ready, check outputs mid-cycle, advance to next negedge
    task automatic cyc(input string tag, input logic mr, input logic [3:0] es, input logic [16:0] ew);
        mem_ready = mr;
        #1;
        check({tag, "_state"}, {28'd0, state}, {28'd0, es});
        check({tag, "_ctl"}, {15'd0, ctl}, {15'd0, ew});
        check({tag, "_pcsrc11"}, {31'd0, (pc_src == 2'b11)}, 32'd0);
        check({tag, "_rdwr"}, {31'd0, (mem_read & mem_write)}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'b100011;
        mem_ready = 1'b1;
        @(negedge clk);

        // reset: outputs blanked even with mem_ready high
        cyc("rst0", 1'b1, T_FETCH, W_ZERO);
        cyc("rst1", 1'b0, T_FETCH, W_ZERO);
        reset = 1'b0;

        // LW with one fetch wait, then 5-cycle LW
        cyc("lw_fwait", 1'b0, T_FETCH, W_F_WAIT);
        cyc("lw_f",     1'b1, T_FETCH, W_F_RDY);
        cyc("lw_dec",   1'b1, T_DECODE, W_DEC);
        cyc("lw_addr",  1'b1, T_MEM_ADDR, W_ADDR);
        cyc("lw_rd",    1'b1, T_MEM_READ, W_MRD);
        cyc("lw_wb",    1'b1, T_MEM_WB, W_MWB);

        // LW interrupted by reset held 2 cycles while waiting in MEM_READ
        cyc("rl_f",     1'b1, T_FETCH, W_F_RDY);
        cyc("rl_dec",   1'b1, T_DECODE, W_DEC);
        cyc("rl_addr",  1'b0, T_MEM_ADDR, W_ADDR);
        cyc("rl_rd",    1'b0, T_MEM_READ, W_MRD);
        reset = 1'b1;
        cyc("rl_rst0",  1'b0, T_MEM_READ, W_ZERO);
        cyc("rl_rst1",  1'b1, T_FETCH, W_ZERO);
        reset = 1'b0;
        cyc("rl_rel",   1'b0, T_FETCH, W_F_WAIT);

        // BEQ
        opcode = 6'b000100;
        cyc("beq_f",    1'b1, T_FETCH, W_F_RDY);
        cyc("beq_dec",  1'b1, T_DECODE, W_DEC);
        cyc("beq_br",   1'b1, T_BRANCH, W_BR);

        // J
        opcode = 6'b000010;
        cyc("j_f",      1'b1, T_FETCH, W_F_RDY);
        cyc("j_dec",    1'b1, T_DECODE, W_DEC);
        cyc("j_jmp",    1'b1, T_JUMP, W_JMP);

        // SW with mem_ready low for 3 cycles in MEM_WRITE
        opcode = 6'b101011;
        cyc("sw_f",     1'b1, T_FETCH, W_F_RDY);
        cyc("sw_dec",   1'b1, T_DECODE, W_DEC);
        cyc("sw_addr",  1'b1, T_MEM_ADDR, W_ADDR);
        cyc("sw_wr0",   1'b0, T_MEM_WRITE, W_MWR);
        cyc("sw_wr1",   1'b0, T_MEM_WRITE, W_MWR);
        cyc("sw_wr2",   1'b0, T_MEM_WRITE, W_MWR);
        cyc("sw_wr3",   1'b1, T_MEM_WRITE, W_MWR);

        // R-type
        opcode = 6'b000000;
        cyc("r_f",      1'b1, T_FETCH, W_F_RDY);
        cyc("r_dec",    1'b1, T_DECODE, W_DEC);
        cyc("r_exe",    1'b1, T_EXECUTE, W_EXE);
        cyc("r_wb",     1'b1, T_R_WB, W_RWB);

        // ADDI
        opcode = 6'b001000;
        cyc("ai_f",     1'b1, T_FETCH, W_F_RDY);
        cyc("ai_dec",   1'b1, T_DECODE, W_DEC);
        cyc("ai_ex",    1'b1, T_ADDI_EX, W_ADDR);
        cyc("ai_wb",    1'b1, T_ADDI_WB, W_AWB);

        // undefined opcode
        opcode = 6'b111111;
        cyc("ill_f",    1'b1, T_FETCH, W_F_RDY);
        cyc("ill_dec",  1'b1, T_DECODE, W_DEC_ILL);
        cyc("ill_back", 1'b0, T_FETCH, W_F_WAIT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
